// File: rtl/video_pkg.sv
// Shared types and default SVGA 800x600@60 (40 MHz) timing for the video output path.
package video_pkg;

    typedef enum logic [1:0] {
        PhActive = 2'd0,
        PhFront  = 2'd1,
        PhSync   = 2'd2,
        PhBack   = 2'd3
    } phase_e;

    typedef logic [23:0] rgb_t;

    localparam rgb_t RGB_BLACK = 24'h000000;

    localparam int unsigned SVGA_H_ACTIVE = 800;
    localparam int unsigned SVGA_H_FP     = 40;
    localparam int unsigned SVGA_H_SYNC   = 128;
    localparam int unsigned SVGA_H_BP     = 88;
    localparam int unsigned SVGA_V_ACTIVE = 600;
    localparam int unsigned SVGA_V_FP     = 1;
    localparam int unsigned SVGA_V_SYNC   = 4;
    localparam int unsigned SVGA_V_BP     = 23;
    localparam bit          SVGA_HSYNC_POL = 1'b1;
    localparam bit          SVGA_VSYNC_POL = 1'b1;
    localparam int unsigned SVGA_CNT_W    = 11;

    function automatic phase_e phase_after(input phase_e p);
        unique case (p)
            PhActive: return PhFront;
            PhFront:  return PhSync;
            PhSync:   return PhBack;
            PhBack:   return PhActive;
        endcase
    endfunction

endpackage

// File: rtl/video_axis_seq.sv
// One raster axis: ACTIVE -> FRONT -> SYNC -> BACK phase FSM with a down-counter
// reloaded to len-1 on entry to each phase; steps only when advance is high.
module video_axis_seq
    import video_pkg::*;
#(
    parameter int unsigned CNT_W = 11
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           advance,
    input  logic [CNT_W:0] len_active,
    input  logic [CNT_W:0] len_front,
    input  logic [CNT_W:0] len_sync,
    input  logic [CNT_W:0] len_back,
    output phase_e         phase,
    output logic           first,
    output logic           last
);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Lengths may equal 2^CNT_W, so len-1 is formed at CNT_W+1 bits and then narrowed.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W:0] len);
        return CNT_W'(len - (CNT_W + 1)'(1));
    endfunction

    function automatic logic [CNT_W:0] sel_len(input phase_e p,
                                               input logic [CNT_W:0] la,
                                               input logic [CNT_W:0] lf,
                                               input logic [CNT_W:0] ls,
                                               input logic [CNT_W:0] lb);
        unique case (p)
            PhActive: return la;
            PhFront:  return lf;
            PhSync:   return ls;
            PhBack:   return lb;
        endcase
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            phase_q <= PhActive;
            count_q <= len_m1(len_active);
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        count_d = count_q;
        if (advance) begin
            if (count_q == '0) begin
                phase_d = phase_after(phase_q);
                count_d = len_m1(sel_len(phase_d, len_active, len_front, len_sync, len_back));
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        phase = phase_q;
        last  = (count_q == '0);
        first = (count_q == len_m1(sel_len(phase_q, len_active, len_front, len_sync,
                                           len_back)));
    end

endmodule

// File: rtl/video_timing_out.sv
// Raster timing generator and output register stage for the display encoder: requests one
// pixel per active cycle and registers pixel, sync, data-enable and frame-start together.
module video_timing_out
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = SVGA_H_ACTIVE,
    parameter int unsigned H_FP      = SVGA_H_FP,
    parameter int unsigned H_SYNC    = SVGA_H_SYNC,
    parameter int unsigned H_BP      = SVGA_H_BP,
    parameter int unsigned V_ACTIVE  = SVGA_V_ACTIVE,
    parameter int unsigned V_FP      = SVGA_V_FP,
    parameter int unsigned V_SYNC    = SVGA_V_SYNC,
    parameter int unsigned V_BP      = SVGA_V_BP,
    parameter bit          HSYNC_POL = SVGA_HSYNC_POL,
    parameter bit          VSYNC_POL = SVGA_VSYNC_POL,
    parameter int unsigned CNT_W     = SVGA_CNT_W
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [23:0] video,
    output logic        VideoReady,
    output logic [23:0] PixelOut,
    output logic        DataEnable,
    output logic        HSync,
    output logic        VSync,
    output logic        FrameStart
);

    localparam int unsigned LEN_W = CNT_W + 1;

    localparam logic [CNT_W:0] H_ACTIVE_LEN = LEN_W'(H_ACTIVE);
    localparam logic [CNT_W:0] H_FP_LEN     = LEN_W'(H_FP);
    localparam logic [CNT_W:0] H_SYNC_LEN   = LEN_W'(H_SYNC);
    localparam logic [CNT_W:0] H_BP_LEN     = LEN_W'(H_BP);
    localparam logic [CNT_W:0] V_ACTIVE_LEN = LEN_W'(V_ACTIVE);
    localparam logic [CNT_W:0] V_FP_LEN     = LEN_W'(V_FP);
    localparam logic [CNT_W:0] V_SYNC_LEN   = LEN_W'(V_SYNC);
    localparam logic [CNT_W:0] V_BP_LEN     = LEN_W'(V_BP);

    phase_e h_phase, v_phase;
    logic   h_first, h_last;
    logic   v_first, v_last_unused;
    logic   line_end;
    logic   video_ready;

    rgb_t   pixel_q, pixel_d;
    logic   de_q, de_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   fs_q, fs_d;

    video_axis_seq #(
        .CNT_W (CNT_W)
    ) u_h_seq (
        .Clock      (Clock),
        .Reset      (Reset),
        .advance    (1'b1),
        .len_active (H_ACTIVE_LEN),
        .len_front  (H_FP_LEN),
        .len_sync   (H_SYNC_LEN),
        .len_back   (H_BP_LEN),
        .phase      (h_phase),
        .first      (h_first),
        .last       (h_last)
    );

    // The vertical axis counts lines, so it steps only on the final cycle of each line.
    assign line_end = (h_phase == PhBack) && h_last;

    video_axis_seq #(
        .CNT_W (CNT_W)
    ) u_v_seq (
        .Clock      (Clock),
        .Reset      (Reset),
        .advance    (line_end),
        .len_active (V_ACTIVE_LEN),
        .len_front  (V_FP_LEN),
        .len_sync   (V_SYNC_LEN),
        .len_back   (V_BP_LEN),
        .phase      (v_phase),
        .first      (v_first),
        .last       (v_last_unused)
    );

    // Decoded from sequencer state only, never from video, so the source sees no loop.
    assign video_ready = (h_phase == PhActive) && (v_phase == PhActive) && !Reset;

    always_comb begin
        de_d    = video_ready;
        pixel_d = video_ready ? video : RGB_BLACK;
        hsync_d = (h_phase == PhSync) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = (v_phase == PhSync) ? VSYNC_POL : ~VSYNC_POL;
        fs_d    = video_ready && h_first && v_first;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pixel_q <= RGB_BLACK;
            de_q    <= 1'b0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            fs_q    <= 1'b0;
        end else begin
            pixel_q <= pixel_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
        end
    end

    assign VideoReady = video_ready;
    assign PixelOut   = pixel_q;
    assign DataEnable = de_q;
    assign HSync      = hsync_q;
    assign VSync      = vsync_q;
    assign FrameStart = fs_q;

endmodule

// File: tb/tb_video_timing_out.sv
// Bench for video_timing_out: SVGA default, a small asymmetric raster (active-low HSync)
// and the minimal 4/1/1/1 x 2/1/1/1 raster, all sharing one clock and reset.
module tb_video_timing_out;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    // SVGA instance with the source stub answering requests.
    logic        s_rdy, s_de, s_hs, s_vs, s_fs;
    logic [23:0] s_pix, s_video;
    assign s_video = s_rdy ? 24'h1ABC9C : 24'hFFFFFF;

    // Small raster: H 6/2/3/2 (13), V 3/1/2/2 (8 lines), HSync active low.
    logic        m_rdy, m_de, m_hs, m_vs, m_fs;
    logic [23:0] m_pix;
    logic [23:0] m_video = 24'h0;

    // Minimal raster: H 4/1/1/1 (7), V 2/1/1/1 (5 lines), CNT_W 2 so len 4 = 2^CNT_W.
    logic        n_rdy, n_de, n_hs, n_vs, n_fs;
    logic [23:0] n_pix;
    logic [23:0] n_video = 24'h00C0DE;

    video_timing_out u_svga (
        .Clock      (Clock),
        .Reset      (Reset),
        .video      (s_video),
        .VideoReady (s_rdy),
        .PixelOut   (s_pix),
        .DataEnable (s_de),
        .HSync      (s_hs),
        .VSync      (s_vs),
        .FrameStart (s_fs)
    );

    video_timing_out #(
        .H_ACTIVE (6), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b1), .CNT_W (3)
    ) u_med (
        .Clock      (Clock),
        .Reset      (Reset),
        .video      (m_video),
        .VideoReady (m_rdy),
        .PixelOut   (m_pix),
        .DataEnable (m_de),
        .HSync      (m_hs),
        .VSync      (m_vs),
        .FrameStart (m_fs)
    );

    video_timing_out #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1), .CNT_W (2)
    ) u_min (
        .Clock      (Clock),
        .Reset      (Reset),
        .video      (n_video),
        .VideoReady (n_rdy),
        .PixelOut   (n_pix),
        .DataEnable (n_de),
        .HSync      (n_hs),
        .VSync      (n_vs),
        .FrameStart (n_fs)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;       // cycles since the last Reset release
    logic [23:0] vid_prev = 24'h0;
    logic svga_on = 1'b1;

    int s_rdy_cnt = 0, s_rdy_fall = -1, s_de_cnt = 0, s_hs_cnt = 0, s_hs_first = -1;
    int s_pix_err = 0;

    localparam int MIN_T = 105;  // 3 frames of 35 cycles plus the trailing register stage

    typedef struct {
        int   t;
        logic rdy, de, hs, vs, fs;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Raster model of the minimal instance: position of cycle tt, outputs of cycle tt-1.
    function automatic logic [31:0] min_model(input int tt);
        logic rdy, de, hs, vs, fs;
        int   p, ph, pl;
        rdy = ((tt % 7) < 4) && (((tt / 7) % 5) < 2);
        if (tt == 0) begin
            de = 1'b0; hs = 1'b0; vs = 1'b0; fs = 1'b0;
        end else begin
            p  = tt - 1;
            ph = p % 7;
            pl = (p / 7) % 5;
            de = (ph < 4) && (pl < 2);
            hs = (ph == 5);
            vs = (pl == 3);
            fs = (ph == 0) && (pl == 0);
        end
        return {3'b000, rdy, de, hs, vs, fs, de ? 24'h00C0DE : 24'h000000};
    endfunction

    task automatic check_min();
        check($sformatf("min_raster t=%0d", t),
              {3'b000, n_rdy, n_de, n_hs, n_vs, n_fs, n_pix}, min_model(t));
    endtask

    task automatic svga_sample();
        if (t <= 1055 && s_rdy) s_rdy_cnt++;
        if (t <= 1055 && !s_rdy && s_rdy_fall < 0) s_rdy_fall = t;
        if (t >= 1 && t <= 1056) begin
            if (s_de) s_de_cnt++;
            if (s_hs) begin
                s_hs_cnt++;
                if (s_hs_first < 0) s_hs_first = t;
            end
            if (s_pix !== ((((t - 1) % 1056) < 800) ? 24'h1ABC9C : 24'h000000)) s_pix_err++;
        end
        if (t == 1) begin
            check("svga_de_fs_t1", 32'({s_de, s_fs}), 32'b11);
            check("svga_pix_t1", 32'(s_pix), 32'h1ABC9C);
        end
    endtask

    task automatic step();
        vid_prev = m_video;
        @(posedge Clock);
        @(negedge Clock);
        t++;
        m_video = {8'h5A, 16'(t)};
        #1;
        if (t <= MIN_T) check_min();
        if (svga_on) svga_sample();
    endtask

    initial begin
        //            t    rdy   de    hs    vs    fs
        vecs[0]  = '{0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{2,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{5,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{6,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{7,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{9,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{11,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{12,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{13,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{14,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{39,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{52,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{53,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{60,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{61,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{78,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{79,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{103, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{104, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{105, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset held for 5 cycles: every instance at its reset values.
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            check($sformatf("reset_hold_med c%0d", i),
                  32'({m_rdy, m_de, m_hs, m_vs, m_fs}), 32'b00100);
            check($sformatf("reset_hold_med_pix c%0d", i), 32'(m_pix), 32'h0);
            check($sformatf("reset_hold_svga c%0d", i),
                  32'({s_rdy, s_de, s_hs, s_vs, s_fs, s_pix}), 32'h0);
            check($sformatf("reset_hold_min c%0d", i),
                  32'({n_rdy, n_de, n_hs, n_vs, n_fs, n_pix}), 32'h0);
        end

        Reset   = 1'b0;
        t       = 0;
        m_video = {8'h5A, 16'h0000};
        #1;
        check("svga_ready_t0", 32'(s_rdy), 32'h1);
        check_min();
        svga_sample();

        for (int i = 0; i < NV; i++) begin
            while (t < vecs[i].t) step();
            check($sformatf("med_vec t=%0d", t),
                  32'({m_rdy, m_de, m_hs, m_vs, m_fs}),
                  32'({vecs[i].rdy, vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].fs}));
            check($sformatf("med_pix t=%0d", t), 32'(m_pix),
                  32'(vecs[i].de ? vid_prev : 24'h0));
        end

        while (t < 1057) step();
        check("svga_ready_next_line", 32'(s_rdy), 32'h1);
        svga_on = 1'b0;
        check("svga_ready_cycles", 32'(s_rdy_cnt), 32'd800);
        check("svga_ready_fall", 32'(s_rdy_fall), 32'd800);
        check("svga_de_cycles", 32'(s_de_cnt), 32'd800);
        check("svga_hsync_cycles", 32'(s_hs_cnt), 32'd128);
        check("svga_hsync_start", 32'(s_hs_first), 32'd841);
        check("svga_pix_errors", 32'(s_pix_err), 32'd0);

        // Mid-frame reset on the small raster at line 1, pixel 3.
        for (int k = 0; k < 200 && (t % 104) != 16; k++) step();
        check("mid_pre_ready", 32'(m_rdy), 32'h1);
        Reset = 1'b1;
        #1;
        check("mid_ready_forced_low", 32'(m_rdy), 32'h0);
        @(posedge Clock);
        @(negedge Clock);
        check("mid_reset_med", 32'({m_rdy, m_de, m_hs, m_vs, m_fs}), 32'b00100);
        check("mid_reset_med_pix", 32'(m_pix), 32'h0);
        check("mid_reset_svga", 32'({s_de, s_hs, s_vs, s_fs, s_pix}), 32'h0);
        Reset   = 1'b0;
        t       = 0;
        m_video = {8'h5A, 16'h0000};
        #1;
        check("mid_release_ready", 32'(m_rdy), 32'h1);
        check_min();
        step();
        check("mid_restart_de_fs", 32'({m_de, m_fs}), 32'b11);
        check("mid_restart_pix", 32'(m_pix), 32'(vid_prev));
        step();
        check("mid_restart_fs_once", 32'(m_fs), 32'h0);
        while (t < 6) step();
        check("mid_restart_ready_end", 32'(m_rdy), 32'h0);
        while (t < 13) step();
        check("mid_restart_line1", 32'({m_rdy, m_de}), 32'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
